alu_acc_multi: RTL and testbench
================================

Name: alu_acc_multi

Overview:
- Parametrised successor of the single-accumulator bus ALU.
- Holds NACC selectable accumulators of width W and a registered bus-output register.
- Supports arithmetic with carry, shift and logic ops, plus a multi-cycle shift-add multiply with a start/busy/done handshake.
- Connects to the shared tristate datapath bus driven by the controller; flags are derived from the freshly written result.

Parameters:
- W, 16, datapath/bus width in bits (>=4).
- NACC, 4, number of accumulators (power of two, >=2).
- OP_W, 8, opcode width.
- SEL_W, $clog2(NACC), accumulator select width (derived; do not override).

Ports:
- clk  in  1  clock, all state changes on rising edge
- nrst  in  1  synchronous reset, active-low
- alu_start  in  1  op valid; opcode, select and operand sampled this edge
- alu_op  in  OP_W  opcode
- alu_sel  in  SEL_W  target accumulator index
- alu_oe  in  1  drive out_reg onto alu_bus
- alu_bus  inout  W  shared bus; operand source; high-Z when alu_oe=0
- alu_busy  out  1  multiply in progress
- alu_done  out  1  one-cycle pulse when any op completes
- alu_zero  out  1  last result == 0
- alu_carry  out  1  carry/borrow/shifted-out bit of last result
- alu_neg  out  1  MSB of last result
- alu_err  out  1  one-cycle pulse on illegal opcode or start while busy

Behaviour:
- Reset (nrst=0 at edge): all accumulators, out_reg, mul state = 0; busy, done and err = 0; zero=1, carry=0, neg=0. Reset mid-multiply aborts it with no done pulse.
- Bus: alu_bus = alu_oe ? out_reg : high-Z, combinational. With alu_oe=1 during an operand op, the operand is out_reg (defined, legal).
- Opcodes. A = acc[sel], B = alu_bus; all arithmetic is modulo 2^W.
  - 00 LOAD A<=B
  - 01 ADD A<=A+B, carry=bit W
  - 02 SUB A<=A-B, carry=borrow
  - 03 NOT A<=~B
  - 04 OR
  - 05 AND
  - 06 XOR
  - 07 INC A<=A+1, carry on wrap
  - 08 STORE out_reg<=A; A and flags unchanged
  - 09 SHL A<=A<<1, carry=old MSB
  - 0A SHR logical, carry=old LSB
  - 0B ADC A<=A+B+carry
  - 0C MUL A<=low W bits of A*B, multi-cycle
  - 0D CLR A<=0
- Single-cycle ops: result written at the start edge; done=1 for the following cycle.
- Flags: updated at that same edge from the new value. Logic ops, LOAD and CLR clear carry. STORE leaves flags unchanged.
- Illegal opcode (>0D): no state change; err=1 next cycle; done=0.
- MUL FSM: IDLE -> RUN -> IDLE.
  - At start: latch multiplicand=A, multiplier=B, product=0, count=0, target=sel; busy=1 next cycle.
  - RUN: each cycle, if multiplier LSB then product+=multiplicand; shift multiplicand left, multiplier right; count++.
  - After W RUN cycles: write product to acc[target], update zero/neg, carry=0. busy drops and done pulses the same cycle. Total latency W+1 edges from start.
- alu_start while busy: ignored (multiply continues); err=1 next cycle.
- Only one op in flight. alu_start in the cycle busy deasserts is accepted only after busy reads 0 (i.e. the next edge).
- Accumulators not selected are never modified.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_LOAD..OP_CLR, OP_LAST=8'h0D)
  - MUL FSM state encoding
  - flag bit indices for any flag vector
- Natural sub-module: alu_mul_seq (shift-add multiplier with start/busy/done), parametrised by W.
- The top level holds the accumulator array, the single-cycle datapath, flags and bus drive.

Test Plan:
- Reset then LOAD sel=2 bus=0x00FF, STORE sel=2, oe=1 -> bus reads 0x00FF; zero=0; acc0/1/3 remain 0.
- LOAD 0xFFFF, ADD 0x0001 (W=16) -> acc=0x0000, zero=1, carry=1; ADC 0x0000 -> acc=0x0001, carry=0.
- SUB: acc=0x0003 minus 0x0005 -> 0xFFFE, carry(borrow)=1, neg=1; SHR -> 0x7FFF, carry=0, neg=0.
- MUL: acc1=0x0012 times 0x0034 -> busy for 16 cycles, done at edge 17, acc1=0x03A8; a start issued mid-run -> err pulse, result unaffected.
- Opcode 0x3F -> err pulse, no accumulator or flag change, done=0.
- nrst=0 during MUL run -> busy=0, no done, all accumulators 0, zero=1; a following LOAD works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, multiplier FSM states
// and flag vector bit positions.
package alu_pkg;

    localparam logic [7:0] OP_LOAD  = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_NOT   = 8'h03;
    localparam logic [7:0] OP_OR    = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_XOR   = 8'h06;
    localparam logic [7:0] OP_INC   = 8'h07;
    localparam logic [7:0] OP_STORE = 8'h08;
    localparam logic [7:0] OP_SHL   = 8'h09;
    localparam logic [7:0] OP_SHR   = 8'h0A;
    localparam logic [7:0] OP_ADC   = 8'h0B;
    localparam logic [7:0] OP_MUL   = 8'h0C;
    localparam logic [7:0] OP_CLR   = 8'h0D;
    localparam logic [7:0] OP_LAST  = 8'h0D;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_N     = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle for W cycles.
// o_fin is high during the last RUN cycle; o_product then holds the final
// product so the caller can commit it on the same edge the FSM leaves RUN.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_start,
    input  logic [W-1:0] i_mcand,
    input  logic [W-1:0] i_mplier,
    output logic         o_busy,
    output logic         o_fin,
    output logic [W-1:0] o_product
);

    localparam int CW = $clog2(W) + 1;

    mul_state_t    r_state;
    mul_state_t    w_state_nxt;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [W-1:0]  r_prod;
    logic [W-1:0]  w_prod_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) r_state <= MUL_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, busy/finish outputs and the accumulated partial product
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_fin       = 1'b0;
        w_last      = (r_cnt == CW'(W - 1));
        w_prod_nxt  = r_prod + (r_mplier[0] ? r_mcand : '0);
        case (r_state)
            MUL_IDLE: if (i_start) w_state_nxt = MUL_RUN;
            MUL_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    o_fin       = 1'b1;
                    w_state_nxt = MUL_IDLE;
                end
            end
            default: w_state_nxt = MUL_IDLE;
        endcase
    end

    assign o_product = w_prod_nxt;

    // Operand latch at start, then one shift-add step per RUN cycle
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == MUL_IDLE && i_start) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == MUL_RUN) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_acc_multi.sv
// Multi-accumulator bus ALU: NACC accumulators, single-cycle arithmetic/logic
// datapath, sequential multiplier, result flags and tristate bus output.
module alu_acc_multi
    import alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int NACC  = 4,
    parameter int OP_W  = 8,
    parameter int SEL_W = $clog2(NACC)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             alu_start,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [SEL_W-1:0] alu_sel,
    input  logic             alu_oe,
    inout  wire  [W-1:0]     alu_bus,
    output logic             alu_busy,
    output logic             alu_done,
    output logic             alu_zero,
    output logic             alu_carry,
    output logic             alu_neg,
    output logic             alu_err
);

    logic [NACC-1:0][W-1:0] r_acc;
    logic [W-1:0]           r_out;
    logic [FLAG_N-1:0]      r_flags;
    logic                   r_done;
    logic                   r_err;
    logic [SEL_W-1:0]       r_mul_sel;

    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W:0]       w_sum;
    logic [W-1:0]     w_res;
    logic             w_cout;
    logic             w_legal;
    logic             w_write;
    logic             w_store;
    logic             w_mul_go;
    logic             w_accept;
    logic             w_busy;
    logic             w_mul_fin;
    logic [W-1:0]     w_mul_prod;
    logic             w_wr_en;
    logic [SEL_W-1:0] w_wr_sel;
    logic [W-1:0]     w_wr_val;
    logic             w_wr_carry;

    // With alu_oe high the DUT itself drives the bus, so take the operand
    // straight from out_reg rather than through the tristate.
    assign w_a     = r_acc[alu_sel];
    assign w_b     = alu_oe ? r_out : alu_bus;
    assign alu_bus = alu_oe ? r_out : 'z;

    // Single-cycle result, carry and op classification
    always_comb begin
        w_sum    = '0;
        w_res    = '0;
        w_cout   = 1'b0;
        w_legal  = 1'b1;
        w_write  = 1'b1;
        w_store  = 1'b0;
        w_mul_go = 1'b0;
        case (alu_op)
            OP_LOAD: w_res = w_b;
            OP_ADD: begin
                w_sum  = {1'b0, w_a} + {1'b0, w_b};
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_SUB: begin
                w_sum  = {1'b0, w_a} - {1'b0, w_b};
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_NOT: w_res = ~w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_AND: w_res = w_a & w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_INC: begin
                w_sum  = {1'b0, w_a} + (W+1)'(1);
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_STORE: begin
                w_write = 1'b0;
                w_store = 1'b1;
            end
            OP_SHL: begin
                w_res  = {w_a[W-2:0], 1'b0};
                w_cout = w_a[W-1];
            end
            OP_SHR: begin
                w_res  = {1'b0, w_a[W-1:1]};
                w_cout = w_a[0];
            end
            OP_ADC: begin
                w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, r_flags[FLAG_CARRY]};
                w_res  = w_sum[W-1:0];
                w_cout = w_sum[W];
            end
            OP_MUL: begin
                w_write  = 1'b0;
                w_mul_go = 1'b1;
            end
            OP_CLR: w_res = '0;
            default: begin
                w_legal = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    assign w_accept = alu_start & ~w_busy & w_legal;

    // Accumulator write port: a finishing multiply and an accepted op never
    // coincide because busy is still high in the multiply's final cycle.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_sel   = alu_sel;
        w_wr_val   = w_res;
        w_wr_carry = w_cout;
        if (w_mul_fin) begin
            w_wr_en    = 1'b1;
            w_wr_sel   = r_mul_sel;
            w_wr_val   = w_mul_prod;
            w_wr_carry = 1'b0;
        end else if (w_accept && w_write) begin
            w_wr_en = 1'b1;
        end
    end

    alu_mul_seq #(.W(W)) u_mul (
        .clk       (clk),
        .nrst      (nrst),
        .i_start   (w_accept & w_mul_go),
        .i_mcand   (w_a),
        .i_mplier  (w_b),
        .o_busy    (w_busy),
        .o_fin     (w_mul_fin),
        .o_product (w_mul_prod)
    );

    // Accumulators, out_reg, flags and the done/err pulses
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_acc     <= '0;
            r_out     <= '0;
            r_flags   <= '0;
            r_flags[FLAG_ZERO] <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_mul_sel <= '0;
        end else begin
            r_done <= w_mul_fin | (w_accept & ~w_mul_go);
            r_err  <= alu_start & (w_busy | ~w_legal);
            if (w_wr_en) begin
                r_acc[w_wr_sel]     <= w_wr_val;
                r_flags[FLAG_ZERO]  <= (w_wr_val == '0);
                r_flags[FLAG_CARRY] <= w_wr_carry;
                r_flags[FLAG_NEG]   <= w_wr_val[W-1];
            end
            if (w_accept && w_store)  r_out     <= w_a;
            if (w_accept && w_mul_go) r_mul_sel <= alu_sel;
        end
    end

    assign alu_busy  = w_busy;
    assign alu_done  = r_done;
    assign alu_err   = r_err;
    assign alu_zero  = r_flags[FLAG_ZERO];
    assign alu_carry = r_flags[FLAG_CARRY];
    assign alu_neg   = r_flags[FLAG_NEG];

endmodule

// File: tb/tb_alu_acc_multi.sv
// Self-checking bench for alu_acc_multi against an arithmetic reference model.
module tb_alu_acc_multi;
    import alu_pkg::*;

    localparam int W    = 16;
    localparam int NACC = 4;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         alu_start = 1'b0;
    logic [7:0]   alu_op = '0;
    logic [1:0]   alu_sel = '0;
    logic         alu_oe = 1'b0;
    logic [W-1:0] drv = '0;
    wire  [W-1:0] alu_bus;
    logic         alu_busy, alu_done, alu_zero, alu_carry, alu_neg, alu_err;

    assign alu_bus = alu_oe ? 'z : drv;

    int checks = 0;
    int failures = 0;

    // Reference model state
    longint unsigned m_acc [NACC];
    longint unsigned m_out;
    bit m_zero, m_carry, m_neg, m_done, m_err;

    alu_acc_multi #(.W(W), .NACC(NACC), .OP_W(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_sel   (alu_sel),
        .alu_oe    (alu_oe),
        .alu_bus   (alu_bus),
        .alu_busy  (alu_busy),
        .alu_done  (alu_done),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_neg   (alu_neg),
        .alu_err   (alu_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) m_acc[i] = 0;
        m_out = 0; m_zero = 1; m_carry = 0; m_neg = 0; m_done = 0; m_err = 0;
    endtask

    // Whole-op semantics; a multiply is modelled as its final result.
    task automatic model_op(input int op, input int sel, input longint unsigned b);
        longint unsigned a, r;
        bit wr, cy;
        a = m_acc[sel]; r = 0; wr = 1; cy = 0;
        m_done = 1; m_err = 0;
        case (op)
            0:  r = b;
            1:  begin r = a + b; cy = (r > MASK); end
            2:  begin cy = (a < b); r = a + (MASK + 1) - b; end
            3:  r = ~b;
            4:  r = a | b;
            5:  r = a & b;
            6:  r = a ^ b;
            7:  begin r = a + 1; cy = (a == MASK); end
            8:  begin m_out = a; wr = 0; end
            9:  begin r = a * 2; cy = (a >= (MASK + 1) / 2); end
            10: begin r = a / 2; cy = a[0]; end
            11: begin r = a + b + m_carry; cy = (r > MASK); end
            12: begin r = a * b; m_done = 0; end
            13: r = 0;
            default: begin wr = 0; m_done = 0; m_err = 1; end
        endcase
        if (wr) begin
            r = r & MASK;
            m_acc[sel] = r;
            m_zero = (r == 0);
            m_carry = cy;
            m_neg = (r >= (MASK + 1) / 2);
        end
    endtask

    // Drive one op for one edge; returns 1 ns after that edge.
    task automatic issue(input int op, input int sel, input longint unsigned b, input bit oe);
        @(negedge clk);
        alu_op = 8'(op); alu_sel = 2'(sel); drv = W'(b); alu_oe = oe; alu_start = 1'b1;
        @(posedge clk);
        #1;
        alu_start = 1'b0; alu_oe = 1'b0;
    endtask

    task automatic do_op(input int op, input int sel, input longint unsigned b, input bit oe);
        longint unsigned beff;
        beff = oe ? m_out : (b & MASK);
        issue(op, sel, b, oe);
        model_op(op, sel, beff);
    endtask

    // STORE the accumulator, then sample it back off the bus.
    task automatic read_acc(input int sel, output logic [W-1:0] v);
        do_op(8, sel, longint'($urandom), 1'b0);
        alu_oe = 1'b1;
        #1;
        v = alu_bus;
        alu_oe = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({alu_busy, alu_done, alu_err, alu_zero, alu_carry, alu_neg} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000100",
                     {alu_busy, alu_done, alu_err, alu_zero, alu_carry, alu_neg});
        end
        alu_oe = 1'b1;
        #1;
        checks++;
        if (alu_bus !== '0) begin
            failures++;
            $display("FAIL reset_bus: got %h expected 0000", alu_bus);
        end
        alu_oe = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int s = 0; s < NACC; s++) begin
            read_acc(s, v);
            checks++;
            if (v !== '0) begin
                failures++;
                $display("FAIL reset_acc%0d: got %h expected 0000", s, v);
            end
        end
    endtask

    task automatic test_load_store();
        logic [W-1:0] v;
        do_op(0, 2, 64'h00FF, 1'b0);
        checks++;
        if ({alu_done, alu_err, alu_zero, alu_carry, alu_neg} !== {m_done, m_err, m_zero, m_carry, m_neg}) begin
            failures++;
            $display("FAIL load_flags: got %b expected %b", {alu_done, alu_err, alu_zero, alu_carry, alu_neg},
                     {m_done, m_err, m_zero, m_carry, m_neg});
        end
        do_op(8, 2, 0, 1'b1);
        checks++;
        if (alu_done !== 1'b1 || alu_zero !== 1'b0) begin
            failures++;
            $display("FAIL store_flags: got done=%b zero=%b expected done=1 zero=0", alu_done, alu_zero);
        end
        alu_oe = 1'b1;
        #1;
        checks++;
        if (alu_bus !== 16'h00FF) begin
            failures++;
            $display("FAIL store_bus: got %h expected 00ff", alu_bus);
        end
        alu_oe = 1'b0;
        for (int s = 0; s < NACC; s++) begin
            if (s == 2) continue;
            read_acc(s, v);
            checks++;
            if (v !== '0) begin
                failures++;
                $display("FAIL unselected_acc%0d: got %h expected 0000", s, v);
            end
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] v;
        do_op(0, 0, 64'hFFFF, 1'b0);
        do_op(1, 0, 64'h0001, 1'b0);
        checks++;
        if ({alu_zero, alu_carry, alu_neg} !== 3'b110) begin
            failures++;
            $display("FAIL add_wrap_flags: got zc n=%b expected 110", {alu_zero, alu_carry, alu_neg});
        end
        do_op(11, 0, 64'h0000, 1'b0);
        read_acc(0, v);
        checks++;
        if (v !== 16'h0001 || alu_carry !== 1'b0) begin
            failures++;
            $display("FAIL adc_carry_in: got acc=%h carry=%b expected acc=0001 carry=0", v, alu_carry);
        end
        do_op(0, 3, 64'h0003, 1'b0);
        do_op(2, 3, 64'h0005, 1'b0);
        checks++;
        if ({alu_zero, alu_carry, alu_neg} !== 3'b011) begin
            failures++;
            $display("FAIL sub_borrow_flags: got %b expected 011", {alu_zero, alu_carry, alu_neg});
        end
        do_op(10, 3, 0, 1'b0);
        read_acc(3, v);
        checks++;
        if (v !== 16'h7FFF || {alu_carry, alu_neg} !== 2'b00) begin
            failures++;
            $display("FAIL shr: got acc=%h c=%b n=%b expected acc=7fff c=0 n=0", v, alu_carry, alu_neg);
        end
    endtask

    task automatic test_random_ops();
        logic [W-1:0] v;
        int op, sel;
        bit oe;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 15);
            if (op == 12) op = 0;
            if (op >= 14) op = $urandom_range(14, 255);
            sel = $urandom_range(0, NACC - 1);
            oe = ($urandom_range(0, 3) == 0);
            do_op(op, sel, longint'($urandom), oe);
            checks++;
            if ({alu_done, alu_err, alu_zero, alu_carry, alu_neg} !== {m_done, m_err, m_zero, m_carry, m_neg}) begin
                failures++;
                $display("FAIL rand_op%0h_flags: got %b expected %b", op,
                         {alu_done, alu_err, alu_zero, alu_carry, alu_neg}, {m_done, m_err, m_zero, m_carry, m_neg});
            end
        end
        for (int s = 0; s < NACC; s++) begin
            read_acc(s, v);
            checks++;
            if (v !== W'(m_acc[s])) begin
                failures++;
                $display("FAIL rand_acc%0d: got %h expected %h", s, v, W'(m_acc[s]));
            end
        end
    endtask

    // Multiply with latency tracking; optionally fires a start mid-run.
    task automatic run_mul(input int sel, input longint unsigned a, input longint unsigned b, input bit poke);
        logic [W-1:0] v;
        int done_edge, busy_bad;
        do_op(0, sel, a, 1'b0);
        do_op(12, sel, b, 1'b0);
        checks++;
        if ({alu_busy, alu_done, alu_err} !== 3'b100) begin
            failures++;
            $display("FAIL mul_start: got busy/done/err=%b expected 100", {alu_busy, alu_done, alu_err});
        end
        done_edge = -1; busy_bad = 0;
        for (int e = 1; e <= 3 * W; e++) begin
            @(negedge clk);
            if (poke && e == 5) begin
                alu_start = 1'b1; alu_op = OP_ADD; alu_sel = 2'(sel); drv = 16'h0007;
            end
            @(posedge clk);
            #1;
            alu_start = 1'b0;
            if (poke && e == 5) begin
                checks++;
                if (alu_err !== 1'b1 || alu_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL mul_busy_start: got err=%b busy=%b expected err=1 busy=1", alu_err, alu_busy);
                end
            end
            if (alu_done === 1'b1) begin
                done_edge = e;
                break;
            end
            if (alu_busy !== 1'b1) busy_bad++;
        end
        checks++;
        if (done_edge != W || busy_bad != 0 || alu_busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_latency: got done_edge=%0d busy_gaps=%0d busy=%b expected %0d 0 0",
                     done_edge, busy_bad, alu_busy, W);
        end
        checks++;
        if ({alu_err, alu_zero, alu_carry, alu_neg} !== {1'b0, m_zero, 1'b0, m_neg}) begin
            failures++;
            $display("FAIL mul_flags: got %b expected %b", {alu_err, alu_zero, alu_carry, alu_neg},
                     {1'b0, m_zero, 1'b0, m_neg});
        end
        m_done = 1;
        read_acc(sel, v);
        checks++;
        if (v !== W'(m_acc[sel])) begin
            failures++;
            $display("FAIL mul_result: got %h expected %h", v, W'(m_acc[sel]));
        end
    endtask

    task automatic test_mul();
        run_mul(1, 64'h0012, 64'h0034, 1'b1);
        checks++;
        if (m_acc[1] != 64'h03A8) begin
            failures++;
            $display("FAIL mul_ref: got %h expected 03a8", m_acc[1]);
        end
        for (int k = 0; k < 3; k++)
            run_mul($urandom_range(0, NACC - 1), longint'($urandom) & MASK, longint'($urandom) & MASK, 1'b0);
    endtask

    task automatic test_illegal();
        logic [W-1:0] v;
        do_op(0, 1, 64'h8000, 1'b0);
        do_op(63, 1, 64'h1234, 1'b0);
        checks++;
        if ({alu_done, alu_err, alu_zero, alu_carry, alu_neg} !== {1'b0, 1'b1, m_zero, m_carry, m_neg}) begin
            failures++;
            $display("FAIL illegal_op: got %b expected %b", {alu_done, alu_err, alu_zero, alu_carry, alu_neg},
                     {1'b0, 1'b1, m_zero, m_carry, m_neg});
        end
        @(posedge clk);
        #1;
        checks++;
        if (alu_err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_err_pulse: got %b expected 0", alu_err);
        end
        read_acc(1, v);
        checks++;
        if (v !== 16'h8000) begin
            failures++;
            $display("FAIL illegal_acc: got %h expected 8000", v);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] v;
        int done_seen;
        do_op(0, 3, 64'h0101, 1'b0);
        do_op(12, 3, 64'h0003, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({alu_busy, alu_done, alu_zero, alu_carry, alu_neg} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_mid_mul: got busy/done/z/c/n=%b expected 00100",
                     {alu_busy, alu_done, alu_zero, alu_carry, alu_neg});
        end
        @(negedge clk);
        nrst = 1'b1;
        done_seen = 0;
        for (int e = 0; e < W + 4; e++) begin
            @(posedge clk);
            #1;
            if (alu_done !== 1'b0 || alu_busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL reset_abort: got %0d done/busy cycles expected 0", done_seen);
        end
        for (int s = 0; s < NACC; s++) begin
            read_acc(s, v);
            checks++;
            if (v !== '0) begin
                failures++;
                $display("FAIL reset_mid_acc%0d: got %h expected 0000", s, v);
            end
        end
        do_op(0, 0, 64'h8001, 1'b0);
        read_acc(0, v);
        checks++;
        if (v !== 16'h8001 || {alu_zero, alu_neg} !== 2'b01) begin
            failures++;
            $display("FAIL load_after_reset: got acc=%h z=%b n=%b expected 8001 0 1", v, alu_zero, alu_neg);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_store();
        test_arith();
        test_random_ops();
        test_mul();
        test_illegal();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
